uart_rx: RTL
============

Name: uart_rx

Overview:
- Serial UART receiver that consumes the asynchronous `uart_rx_i` line and writes each received byte into the receive FIFO's write port.
- Oversamples the line and validates the start bit, then shifts in data LSB-first and checks the stop bit.
- Reports framing errors, and overruns when the FIFO is full.
- Sits directly upstream of the RX FWFT FIFO inside the UART top level.

Parameters:
- CLK_FREQ_HZ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115_200: line bit rate in bits/s.
- OVERSAMPLE, 16: sample ticks per bit. Must be even and ≥ 4.
- DATA_BITS, 8: data bits per frame. Legal range 5–8; no parity; one stop bit.
- Derived DIV = CLK_FREQ_HZ / (BAUD_RATE*OVERSAMPLE), integer-truncated. DIV must be ≥ 1; elaboration-time assertion otherwise.

Ports:
- clk_i, in, 1: system clock. Everything is on the rising edge.
- rst_i, in, 1: asynchronous, active-high reset.
- uart_rx_i, in, 1: asynchronous serial input. Idle level is high.
- fifo_full_i, in, 1: RX FIFO full flag.
- rx_data_o, out, DATA_BITS: received byte, LSB = first bit on the line. Valid only while rx_wr_en_o = 1.
- rx_wr_en_o, out, 1: one-cycle FIFO write strobe.
- frame_err_o, out, 1: one-cycle pulse when the stop bit samples low.
- overrun_o, out, 1: one-cycle pulse when a good frame is dropped because the FIFO is full.
- rx_busy_o, out, 1: high in every state except IDLE.

Behaviour:
- Reset (async assert, sync-released by the system):
  - All outputs 0; state IDLE.
  - Both synchronizer flops are set to 1 (idle line), so no false start occurs out of reset.
  - All counters 0; shift register 0.
  - Reset mid-frame aborts the frame with no write and no error pulse.
- Synchronizer: 2-flop chain on uart_rx_i; `rx_s` is the second flop. The FSM uses only `rx_s`.
- Tick generator:
  - `div_cnt` counts 0..DIV-1; `tick` = 1 when div_cnt == DIV-1, then wraps to 0.
  - `div_cnt` is forced to 0 in IDLE, so the sample phase aligns to the start edge.
- Oversample counter `os_cnt`: 0..OVERSAMPLE-1; advances only on `tick`.
- FSM, states IDLE, START, DATA, STOP, WAIT_HIGH:
  - IDLE: when rx_s = 0, go to START with div_cnt = 0, os_cnt = 0.
  - START: on tick with os_cnt == OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - rx_s = 1: glitch; return to IDLE with no outputs.
    - rx_s = 0: clear os_cnt, clear bit_cnt, go to DATA.
  - DATA: on tick with os_cnt == OVERSAMPLE-1 (mid bit), shift right with rx_s entering the MSB of a DATA_BITS register, and clear os_cnt.
    - When bit_cnt == DATA_BITS-1, go to STOP; otherwise increment bit_cnt.
  - STOP: on tick with os_cnt == OVERSAMPLE-1, sample the stop bit:
    - rx_s = 1 and fifo_full_i = 0: next cycle rx_wr_en_o = 1 and rx_data_o = shift register; go to IDLE.
    - rx_s = 1 and fifo_full_i = 1: next cycle overrun_o = 1, no write; go to IDLE.
    - rx_s = 0: next cycle frame_err_o = 1, no write (a break also lands here); go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a held-low line from retriggering.
- Timing:
  - Returning to IDLE at mid-stop-bit lets a back-to-back start bit be detected.
  - Latency from the line's stop-bit midpoint to rx_wr_en_o is 2 synchronizer cycles + 1 cycle.
- Pulses:
  - rx_wr_en_o, overrun_o and frame_err_o are registered, single-cycle and mutually exclusive.
  - rx_data_o holds its last written value otherwise.
- fifo_full_i is sampled only at the stop-bit decision cycle.
- With DATA_BITS < 8, the byte is right-aligned (bits above DATA_BITS-1 of a narrower FIFO word are a top-level concern).

Test Plan:
- Use CLK_FREQ_HZ=3_200_000, BAUD_RATE=100_000, OVERSAMPLE=16 (DIV=2, 32 clk/bit).
- Frame 0xA5 (line: 0,1,0,1,0,0,1,0,1,1) -> exactly one rx_wr_en_o pulse with rx_data_o=0xA5; frame_err_o=overrun_o=0; rx_busy_o returns low.
- Back-to-back frames 0x00, 0xFF, 0x3C with no idle gap -> three writes in order, values exact, none dropped.
- Low glitch of 8 clk on an idle line -> no write, no error, FSM back to IDLE within 24 clk.
- Frame 0x55 with stop bit driven 0, then line held low 100 clk -> single frame_err_o pulse, no write. No new frame until the line returns high; a following 0x12 frame is received correctly.
- fifo_full_i=1 during frame 0x77 -> overrun_o pulses once, rx_wr_en_o stays 0. Next frame 0x88 with full=0 is written.
- rst_i asserted during DATA bit 4 of 0xC3 -> all outputs 0 immediately, no write. A fresh 0x5A after release is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - UART receiver to RX FIFO write-port interface
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data_o;
  logic                 rx_wr_en_o;
  logic                 frame_err_o;
  logic                 overrun_o;
  logic                 rx_busy_o;
  logic                 fifo_full_i;

  modport master (
    output rx_data_o,
    output rx_wr_en_o,
    output frame_err_o,
    output overrun_o,
    output rx_busy_o,
    input  fifo_full_i
  );

  modport slave (
    input  rx_data_o,
    input  rx_wr_en_o,
    input  frame_err_o,
    input  overrun_o,
    input  rx_busy_o,
    output fifo_full_i
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling UART receiver feeding the RX FIFO write port
module uart_rx #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       uart_rx_i,
  uart_rx_if.master  fifo
);
  localparam int DIV   = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx: clock too slow for BAUD_RATE*OVERSAMPLE");
  end
  if ((OVERSAMPLE % 2) != 0 || OVERSAMPLE < 4) begin : g_bad_os
    $error("uart_rx: OVERSAMPLE must be even and at least 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_bits
    $error("uart_rx: DATA_BITS must be 5 to 8");
  end

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t               state;
  logic                 rx_meta;
  logic                 rx_s;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 tick;

  assign tick = (div_cnt == DIV_W'(DIV - 1));

  // Synchronizer resets to the idle-high level so reset release never looks like a start edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state            <= IDLE;
      div_cnt          <= '0;
      os_cnt           <= '0;
      bit_cnt          <= '0;
      shreg            <= '0;
      fifo.rx_data_o   <= '0;
      fifo.rx_wr_en_o  <= 1'b0;
      fifo.frame_err_o <= 1'b0;
      fifo.overrun_o   <= 1'b0;
      fifo.rx_busy_o   <= 1'b0;
    end else begin
      fifo.rx_wr_en_o  <= 1'b0;
      fifo.frame_err_o <= 1'b0;
      fifo.overrun_o   <= 1'b0;

      // Divider is held at zero while idle so sample phase is locked to the start edge.
      if (state == IDLE || tick) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state          <= START;
            os_cnt         <= '0;
            fifo.rx_busy_o <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (os_cnt == OS_W'(OVERSAMPLE / 2 - 1)) begin
              if (rx_s) begin
                state          <= IDLE;
                fifo.rx_busy_o <= 1'b0;
              end else begin
                state   <= DATA;
                os_cnt  <= '0;
                bit_cnt <= '0;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (tick) begin
            if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
              os_cnt <= '0;
              shreg  <= {rx_s, shreg[DATA_BITS-1:1]};
              if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                state <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        STOP: begin
          if (tick) begin
            if (os_cnt == OS_W'(OVERSAMPLE - 1)) begin
              os_cnt <= '0;
              if (rx_s) begin
                state          <= IDLE;
                fifo.rx_busy_o <= 1'b0;
                if (fifo.fifo_full_i) begin
                  fifo.overrun_o <= 1'b1;
                end else begin
                  fifo.rx_wr_en_o <= 1'b1;
                  fifo.rx_data_o  <= shreg;
                end
              end else begin
                state            <= WAIT_HIGH;
                fifo.frame_err_o <= 1'b1;
              end
            end else begin
              os_cnt <= os_cnt + 1'b1;
            end
          end
        end

        WAIT_HIGH: begin
          if (rx_s) begin
            state          <= IDLE;
            fifo.rx_busy_o <= 1'b0;
          end
        end

        default: begin
          state          <= IDLE;
          fifo.rx_busy_o <= 1'b0;
        end
      endcase
    end
  end
endmodule
